fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS datapath. It owns the PC, drives the instruction-memory request handshake, and presents each fetched instruction and its address to the IF/ID pipeline register through `enable_IF_ID` and `flush_IF_ID`. It absorbs downstream stalls with a one-entry hold buffer and honours branch/jump redirects without violating the address-stable rule of the instruction cache.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_hold_buf.sv | 39 +++
 rtl/fetch_stage.sv | 137 +++++++++++++
 tb/tb_fetch_stage.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and constants.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  localparam word_t PC_INIT_DEFAULT = 32'h0000_0000;
  localparam word_t PC_STEP         = 32'd4;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2,
    HALTED  = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Port bundle for the instruction-fetch stage: datapath side and bench side.
interface fetch_stage_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t imemaddr;
  logic  stall;
  logic  redirect;
  word_t redirect_addr;
  logic  halt;
  word_t instruction;
  word_t pc_out;
  word_t npc;
  logic  enable_IF_ID;
  logic  flush_IF_ID;

  modport datapath (
    input  ihit, imemload, stall, redirect, redirect_addr, halt,
    output iREN, imemaddr, instruction, pc_out, npc, enable_IF_ID, flush_IF_ID
  );

  modport tb (
    output ihit, imemload, stall, redirect, redirect_addr, halt,
    input  iREN, imemaddr, instruction, pc_out, npc, enable_IF_ID, flush_IF_ID
  );
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry instruction/PC buffer that absorbs a fetched word while IF/ID is stalled.
module fetch_hold_buf
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  load_i,
  input  logic  clear_i,
  input  word_t instr_i,
  input  word_t pc_i,
  output word_t instr_o,
  output word_t pc_o,
  output logic  valid_o
);
  word_t instr_q;
  word_t pc_q;
  logic  valid_q;

  // Clear wins over load so a redirect always drops the held word.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem handshake, feeds IF/ID.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = PC_INIT_DEFAULT
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ihit,
  input  word_t imemload,
  output logic  iREN,
  output word_t imemaddr,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_addr,
  input  logic  halt,
  output word_t instruction,
  output word_t pc_out,
  output word_t npc,
  output logic  enable_IF_ID,
  output logic  flush_IF_ID
);
  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        pend_q, pend_d;
  logic         buf_load, buf_clear, buf_valid;
  word_t        buf_instr, buf_pc;

  fetch_hold_buf u_hold_buf (
    .CLK     (CLK),
    .nRST    (nRST),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .instr_i (imemload),
    .pc_i    (pc_q),
    .instr_o (buf_instr),
    .pc_o    (buf_pc),
    .valid_o (buf_valid)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    buf_load     = 1'b0;
    buf_clear    = 1'b0;
    enable_IF_ID = 1'b0;
    instruction  = '0;
    pc_out       = '0;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          if (ihit) begin
            pc_d = redirect_addr;
          end else begin
            pend_d  = redirect_addr;
            state_d = DISCARD;
          end
        end else begin
          if (ihit && !stall) begin
            enable_IF_ID = 1'b1;
            instruction  = imemload;
            pc_out       = pc_q;
          end
          if (halt) begin
            state_d = HALTED;
          end else if (ihit) begin
            pc_d = pc_q + PC_STEP;
            if (stall) begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end
          end
        end
      end
      // The in-flight request must complete at the old address before retargeting.
      DISCARD: begin
        if (redirect) begin
          if (ihit) begin
            pc_d    = redirect_addr;
            state_d = FETCH;
          end else begin
            pend_d = redirect_addr;
          end
        end else if (halt) begin
          state_d = HALTED;
        end else if (ihit) begin
          pc_d    = pend_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          buf_clear = 1'b1;
          pc_d      = redirect_addr;
          state_d   = FETCH;
        end else begin
          if (!stall && buf_valid) begin
            enable_IF_ID = 1'b1;
            instruction  = buf_instr;
            pc_out       = buf_pc;
          end
          if (halt) begin
            buf_clear = 1'b1;
            state_d   = HALTED;
          end else if (!stall) begin
            buf_clear = 1'b1;
            state_d   = FETCH;
          end
        end
      end
      default: ;
    endcase
    if (!nRST) begin
      enable_IF_ID = 1'b0;
      instruction  = '0;
      pc_out       = '0;
    end
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  assign iREN        = (state_q == FETCH) || (state_q == DISCARD);
  assign imemaddr    = pc_q;
  assign npc         = pc_out + PC_STEP;
  assign flush_IF_ID = redirect;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed walk-through plus randomized traffic vs. a behavioural model.
module tb_fetch_stage;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b1;
  always #5 CLK = ~CLK;

  fetch_stage_if fif ();

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST),
    .ihit(fif.ihit), .imemload(fif.imemload),
    .iREN(fif.iREN), .imemaddr(fif.imemaddr),
    .stall(fif.stall), .redirect(fif.redirect), .redirect_addr(fif.redirect_addr), .halt(fif.halt),
    .instruction(fif.instruction), .pc_out(fif.pc_out), .npc(fif.npc),
    .enable_IF_ID(fif.enable_IF_ID), .flush_IF_ID(fif.flush_IF_ID)
  );

  logic  ihit2 = 1'b0;
  word_t imemload2 = '0;
  logic  iREN2, en2, flush2;
  word_t imemaddr2, instruction2, pc_out2, npc2;

  fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) dut_wrap (
    .CLK(CLK), .nRST(nRST),
    .ihit(ihit2), .imemload(imemload2),
    .iREN(iREN2), .imemaddr(imemaddr2),
    .stall(1'b0), .redirect(1'b0), .redirect_addr(32'h0), .halt(1'b0),
    .instruction(instruction2), .pc_out(pc_out2), .npc(npc2),
    .enable_IF_ID(en2), .flush_IF_ID(flush2)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input word_t got, input word_t exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Behavioural model: the PC, an outstanding redirect target, a held word, and a halted flag.
  word_t m_pc, m_pend, m_hi, m_hp;
  bit    m_disc, m_hold, m_halt;

  task automatic model_reset();
    m_pc = 32'h0; m_pend = '0; m_hi = '0; m_hp = '0;
    m_disc = 0; m_hold = 0; m_halt = 0;
  endtask

  task automatic model_out(output bit ren, output bit en, output word_t ins, output word_t pco);
    ren = !m_halt && !m_hold;
    en = 0; ins = '0; pco = '0;
    if (!m_halt && !fif.redirect && !fif.stall) begin
      if (m_hold) begin
        en = 1; ins = m_hi; pco = m_hp;
      end else if (!m_disc && fif.ihit) begin
        en = 1; ins = fif.imemload; pco = m_pc;
      end
    end
  endtask

  task automatic model_edge();
    if (m_halt) return;
    if (fif.redirect) begin
      if (m_hold) begin m_hold = 0; m_pc = fif.redirect_addr; end
      else if (fif.ihit) begin m_disc = 0; m_pc = fif.redirect_addr; end
      else begin m_disc = 1; m_pend = fif.redirect_addr; end
    end else if (fif.halt) begin
      m_halt = 1; m_hold = 0; m_disc = 0;
    end else if (m_hold) begin
      if (!fif.stall) m_hold = 0;
    end else if (m_disc) begin
      if (fif.ihit) begin m_disc = 0; m_pc = m_pend; end
    end else if (fif.ihit) begin
      if (fif.stall) begin m_hold = 1; m_hi = fif.imemload; m_hp = m_pc; end
      m_pc = m_pc + 32'd4;
    end
  endtask

  word_t obs_ins, obs_pc;
  logic  obs_en, obs_flush;

  // One clock cycle: drive, check mid-cycle against the model, advance on the edge.
  task automatic step(input logic ih, input word_t ld, input logic st,
                      input logic rd, input word_t ra, input logic hl);
    bit ren, en;
    word_t ins, pco;
    fif.ihit = ih; fif.imemload = ld; fif.stall = st;
    fif.redirect = rd; fif.redirect_addr = ra; fif.halt = hl;
    #3;
    model_out(ren, en, ins, pco);
    check("iREN", fif.iREN, ren);
    if (ren) check("imemaddr", fif.imemaddr, m_pc);
    check("enable_IF_ID", fif.enable_IF_ID, en);
    check("instruction", fif.instruction, ins);
    check("pc_out", fif.pc_out, pco);
    check("npc", fif.npc, pco + 32'd4);
    check("flush_IF_ID", fif.flush_IF_ID, rd);
    obs_en = fif.enable_IF_ID; obs_ins = fif.instruction;
    obs_pc = fif.pc_out; obs_flush = fif.flush_IF_ID;
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    fif.redirect = 1; fif.ihit = 1; fif.imemload = 32'h1234_5678;
    fif.stall = 0; fif.halt = 0; ihit2 = 0;
    nRST = 0;
    #1;
    check("rst_iREN", fif.iREN, 1);
    check("rst_imemaddr", fif.imemaddr, 32'h0);
    check("rst_enable", fif.enable_IF_ID, 0);
    check("rst_instruction", fif.instruction, 0);
    check("rst_pc_out", fif.pc_out, 0);
    check("rst_npc", fif.npc, 32'd4);
    check("rst_flush", fif.flush_IF_ID, 1);
    check("rst_imemaddr_wrap", imemaddr2, 32'hFFFF_FFFC);
    model_reset();
    @(posedge CLK);
    #1;
    nRST = 1; fif.redirect = 0; fif.ihit = 0;
  endtask

  initial begin
    fif.ihit = 0; fif.imemload = '0; fif.stall = 0;
    fif.redirect = 0; fif.redirect_addr = '0; fif.halt = 0;
    #2;
    do_reset();

    // Wrap-around instance: one hit at 0xFFFF_FFFC.
    ihit2 = 1; imemload2 = 32'hCAFE_0001;
    #3;
    check("wrap_en", en2, 1);
    check("wrap_pc_out", pc_out2, 32'hFFFF_FFFC);
    check("wrap_npc", npc2, 32'h0);
    @(posedge CLK); #1;
    ihit2 = 0;
    check("wrap_next_addr", imemaddr2, 32'h0);

    // Straight-line fetch.
    step(1, 32'h2001_0005, 0, 0, 0, 0);
    check("tp_en0", obs_en, 1); check("tp_pc0", obs_pc, 32'h0);
    step(1, 32'h2002_0007, 0, 0, 0, 0);
    check("tp_en1", obs_en, 1); check("tp_pc1", obs_pc, 32'h4);
    check("tp_addr8", fif.imemaddr, 32'h8);

    // Stall absorbed by the hold buffer.
    step(1, 32'hDEAD_BEEF, 1, 0, 0, 0);
    check("tp_hold_iren", fif.iREN, 0);
    step(0, 32'h0, 1, 0, 0, 0);
    step(0, 32'h0, 1, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0, 0);
    check("tp_rel_en", obs_en, 1); check("tp_rel_ins", obs_ins, 32'hDEAD_BEEF);
    check("tp_rel_pc", obs_pc, 32'h8); check("tp_addr12", fif.imemaddr, 32'hC);

    // Redirect with a request in flight.
    step(0, 32'h0, 0, 1, 32'h40, 0);
    check("tp_flush", obs_flush, 1); check("tp_addr_stable", fif.imemaddr, 32'hC);
    step(0, 32'h0, 0, 0, 0, 0);
    check("tp_addr_stable2", fif.imemaddr, 32'hC);
    step(1, 32'h1111_1111, 0, 0, 0, 0);
    check("tp_disc_en", obs_en, 0); check("tp_addr40", fif.imemaddr, 32'h40);

    // Redirect in HOLD beats stall release.
    step(1, 32'h2222_2222, 1, 0, 0, 0);
    step(0, 32'h0, 0, 1, 32'h80, 0);
    check("tp_hold_redir_en", obs_en, 0); check("tp_addr80", fif.imemaddr, 32'h80);

    // Redirect beats halt; a lone halt then stops fetching until reset.
    step(1, 32'h3333_3333, 0, 1, 32'h100, 1);
    check("tp_nohalt_iren", fif.iREN, 1); check("tp_addr100", fif.imemaddr, 32'h100);
    step(0, 32'h0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 0, 0, 0, 0);
      check("tp_halted_iren", fif.iREN, 0);
    end
    do_reset();
    check("tp_post_rst_addr", fif.imemaddr, 32'h0);

    for (int c = 0; c < 1500; c++) begin
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0)
        do_reset();
      else
        step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) == 0,
             $urandom_range(0, 9) == 0, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
